// File: rtl/cc_threshold_cmp_pkg.sv
// Shared encodings for the debounced threshold comparator.
package cc_threshold_cmp_pkg;

  typedef enum logic [2:0] {
    MODE_LT = 3'd0,
    MODE_LE = 3'd1,
    MODE_EQ = 3'd2,
    MODE_GE = 3'd3,
    MODE_GT = 3'd4,
    MODE_NE = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_ARM    = 2'd1,
    S_SET    = 2'd2,
    S_DISARM = 2'd3
  } state_e;

  // Threshold value after reset; truncated to the data width at use.
  localparam logic [31:0] RST_THRESHOLD = 32'd0;

endpackage

// File: rtl/cc_threshold_cmp_if.sv
// Compare bus: operands and mode in, match condition out.
interface cc_threshold_cmp_if #(
  parameter int DW = 8
);
  logic [DW-1:0] data;
  logic [DW-1:0] threshold;
  logic [2:0]    mode;
  logic          cond;

  modport master (output data, output threshold, output mode, input cond);
  modport slave  (input data, input threshold, input mode, output cond);
endinterface

// File: rtl/cc_compare_core.sv
// Combinational compare of data against threshold under the selected mode.
// Define CC_THRESHOLD_CMP_SIGNED_EN for two's-complement operands; default
// build compares unsigned.
module cc_compare_core
  import cc_threshold_cmp_pkg::*;
(
  cc_threshold_cmp_if.slave cmp
);

  logic lt;
  logic eq;

`ifdef CC_THRESHOLD_CMP_SIGNED_EN
  assign lt = $signed(cmp.data) < $signed(cmp.threshold);
`else
  assign lt = cmp.data < cmp.threshold;
`endif
  assign eq = (cmp.data == cmp.threshold);

  // Select the relation; reserved modes never match.
  always_comb begin
    cmp.cond = 1'b0;
    case (cmp.mode)
      MODE_LT: cmp.cond = lt;
      MODE_LE: cmp.cond = lt | eq;
      MODE_EQ: cmp.cond = eq;
      MODE_GE: cmp.cond = ~lt;
      MODE_GT: cmp.cond = ~lt & ~eq;
      MODE_NE: cmp.cond = ~eq;
      default: cmp.cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/cc_threshold_cmp.sv
// Debounced threshold comparator: match asserts (low) after PERSIST_CYCLES
// consecutive valid samples meeting the condition and releases after the same
// number failing it. Signed compare selected by CC_THRESHOLD_CMP_SIGNED_EN.
module cc_threshold_cmp
  import cc_threshold_cmp_pkg::*;
#(
  parameter int NUMBER_DATAWIDTH = 8,
  parameter int PERSIST_CYCLES   = 4
) (
  input  logic                        CC_THRESHOLD_CMP_CLOCK_50,
  input  logic                        CC_THRESHOLD_CMP_RESET_InLow,
  input  logic [NUMBER_DATAWIDTH-1:0] CC_THRESHOLD_CMP_data_InBUS,
  input  logic                        CC_THRESHOLD_CMP_dataValid_InHigh,
  input  logic [NUMBER_DATAWIDTH-1:0] CC_THRESHOLD_CMP_threshold_InBUS,
  input  logic [2:0]                  CC_THRESHOLD_CMP_mode_InBUS,
  input  logic                        CC_THRESHOLD_CMP_load_InHigh,
  output logic                        CC_THRESHOLD_CMP_match_OutLow,
  output logic                        CC_THRESHOLD_CMP_edge_OutHigh
);

  localparam int CW = $clog2(PERSIST_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERSIST_CYCLES - 1);

  wire clk   = CC_THRESHOLD_CMP_CLOCK_50;
  wire rst_n = CC_THRESHOLD_CMP_RESET_InLow;
  wire valid = CC_THRESHOLD_CMP_dataValid_InHigh;
  wire load  = CC_THRESHOLD_CMP_load_InHigh;

  state_e                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [NUMBER_DATAWIDTH-1:0] thr_q;
  logic [2:0]            mode_q;
  logic                  match_q, match_nxt;
  logic                  edge_q;
  logic                  cond;

  cc_threshold_cmp_if #(.DW(NUMBER_DATAWIDTH)) cmp_bus ();

  assign cmp_bus.data      = CC_THRESHOLD_CMP_data_InBUS;
  assign cmp_bus.threshold = thr_q;
  assign cmp_bus.mode      = mode_q;
  assign cond              = cmp_bus.cond;

  cc_compare_core u_core (.cmp(cmp_bus.slave));

  // State and persistence counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: load aborts any partial run; otherwise only valid samples
  // advance the debounce. The counter is zeroed whenever a run completes or
  // breaks, so it never passes PERSIST_CYCLES.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (load) begin
      cnt_nxt = '0;
      if (state == S_ARM)    state_nxt = S_CLEAR;
      if (state == S_DISARM) state_nxt = S_SET;
    end else if (valid) begin
      case (state)
        S_CLEAR: if (cond) begin
          if (PERSIST_CYCLES == 1) begin
            state_nxt = S_SET;
            cnt_nxt   = '0;
          end else begin
            state_nxt = S_ARM;
            cnt_nxt   = CW'(1);
          end
        end
        S_ARM: if (cond) begin
          if (cnt >= CNT_LAST) begin
            state_nxt = S_SET;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end else begin
          state_nxt = S_CLEAR;
          cnt_nxt   = '0;
        end
        S_SET: if (!cond) begin
          if (PERSIST_CYCLES == 1) begin
            state_nxt = S_CLEAR;
            cnt_nxt   = '0;
          end else begin
            state_nxt = S_DISARM;
            cnt_nxt   = CW'(1);
          end
        end
        S_DISARM: if (!cond) begin
          if (cnt >= CNT_LAST) begin
            state_nxt = S_CLEAR;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end else begin
          state_nxt = S_SET;
          cnt_nxt   = '0;
        end
        default: begin
          state_nxt = S_CLEAR;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Match is asserted (low) in the two matched states; computed from the next
  // state so the registered output moves on the qualifying sample's edge.
  always_comb begin
    match_nxt = ~((state_nxt == S_SET) || (state_nxt == S_DISARM));
  end

  // Config registers, registered match and its transition pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q   <= NUMBER_DATAWIDTH'(RST_THRESHOLD);
      mode_q  <= MODE_LT;
      match_q <= 1'b1;
      edge_q  <= 1'b0;
    end else begin
      if (load) begin
        thr_q  <= CC_THRESHOLD_CMP_threshold_InBUS;
        mode_q <= CC_THRESHOLD_CMP_mode_InBUS;
      end
      match_q <= match_nxt;
      edge_q  <= (match_nxt != match_q);
    end
  end

  assign CC_THRESHOLD_CMP_match_OutLow = match_q;
  assign CC_THRESHOLD_CMP_edge_OutHigh = edge_q;

endmodule

// File: tb/tb_cc_threshold_cmp.sv
// Randomized + directed bench for cc_threshold_cmp against a run-length model.
module tb_cc_threshold_cmp;
  localparam int W = 8;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] data = '0;
  logic [W-1:0] thr = '0;
  logic [2:0]   mode = '0;
  logic         valid = 1'b0;
  logic         load = 1'b0;
  logic         match_n;
  logic         edge_p;

  always #5 clk = ~clk;

  cc_threshold_cmp #(.NUMBER_DATAWIDTH(W), .PERSIST_CYCLES(P)) dut (
    .CC_THRESHOLD_CMP_CLOCK_50        (clk),
    .CC_THRESHOLD_CMP_RESET_InLow     (rst_n),
    .CC_THRESHOLD_CMP_data_InBUS      (data),
    .CC_THRESHOLD_CMP_dataValid_InHigh(valid),
    .CC_THRESHOLD_CMP_threshold_InBUS (thr),
    .CC_THRESHOLD_CMP_mode_InBUS      (mode),
    .CC_THRESHOLD_CMP_load_InHigh     (load),
    .CC_THRESHOLD_CMP_match_OutLow    (match_n),
    .CC_THRESHOLD_CMP_edge_OutHigh    (edge_p)
  );

  // Standalone compare core for direct condition checks.
  cc_threshold_cmp_if #(.DW(W)) ub ();
  cc_compare_core u_core (.cmp(ub.slave));

  int checks = 0;
  int errors = 0;

  // Model: matched flag plus length of the current run of valid samples
  // that argue for flipping it.
  bit m_match;
  int m_run;
  int m_thr;
  int m_mode;
  bit m_edge;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_cond(input int d, input int t, input int m);
    int a = d;
    int b = t;
`ifdef CC_THRESHOLD_CMP_SIGNED_EN
    if (a >= 2 ** (W - 1)) a -= 2 ** W;
    if (b >= 2 ** (W - 1)) b -= 2 ** W;
`endif
    case (m)
      0: return a < b;
      1: return a <= b;
      2: return a == b;
      3: return a >= b;
      4: return a > b;
      5: return a != b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_reset();
    m_match = 0; m_run = 0; m_thr = 0; m_mode = 0; m_edge = 0;
  endfunction

  // One clock: drive at negedge, model at posedge, check at next negedge.
  task automatic cyc(input bit v, input int d, input bit ld, input int t, input int m);
    valid = v; data = W'(d); load = ld; thr = W'(t); mode = 3'(m);
    @(posedge clk);
    m_edge = 0;
    if (ld) begin
      m_thr = t % (2 ** W); m_mode = m % 8; m_run = 0;
    end else if (v) begin
      if (ref_cond(d % (2 ** W), m_thr, m_mode) != m_match) begin
        m_run++;
        if (m_run == P) begin
          m_match = !m_match; m_run = 0; m_edge = 1;
        end
      end else begin
        m_run = 0;
      end
    end
    @(negedge clk);
    chk("match", 32'(match_n), 32'(!m_match));
    chk("edge", 32'(edge_p), 32'(m_edge));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_match", 32'(match_n), 32'd1);
    chk("rst_edge", 32'(edge_p), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    valid = 0; load = 0;
    @(negedge clk);
    do_reset();

    // Scenario 1: GE 100, four samples of 120.
    cyc(0, 0, 1, 100, 3);
    for (int i = 0; i < 4; i++) cyc(1, 120, 0, 0, 0);
    chk("s1_match", 32'(match_n), 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("s1_edge_once", 32'(edge_p), 32'd0);

    // Scenario 2: a dip restarts the run.
    do_reset();
    cyc(0, 0, 1, 100, 3);
    begin
      int s2 [7] = '{120, 120, 90, 120, 120, 120, 120};
      for (int i = 0; i < 7; i++) begin
        cyc(1, s2[i], 0, 0, 0);
        if (i == 5) chk("s2_not_yet", 32'(match_n), 32'd1);
      end
    end
    chk("s2_match", 32'(match_n), 32'd0);

    // Scenario 3: release with invalid gaps carrying stray data.
    for (int i = 0; i < 4; i++) begin
      cyc(1, 50, 0, 0, 0);
      cyc(0, 200, 0, 0, 0);
      if (i == 2) chk("s3_held", 32'(match_n), 32'd0);
    end
    chk("s3_release", 32'(match_n), 32'd1);

    // Scenario 4: signedness of LT 0x10 vs 0xF0.
    ub.data = 8'hF0; ub.threshold = 8'h10; ub.mode = 3'd0;
    #1;
`ifdef CC_THRESHOLD_CMP_SIGNED_EN
    chk("s4_cond", 32'(ub.cond), 32'd1);
`else
    chk("s4_cond", 32'(ub.cond), 32'd0);
`endif
    cyc(0, 0, 1, 16'h10, 0);
    for (int i = 0; i < 4; i++) cyc(1, 8'hF0, 0, 0, 0);

    // Scenario 5: reset mid-arm (counter 3), then four fresh samples needed.
    do_reset();
    cyc(0, 0, 1, 100, 3);
    for (int i = 0; i < 3; i++) cyc(1, 120, 0, 0, 0);
    #2;
    do_reset();
    cyc(0, 0, 1, 100, 3);
    for (int i = 0; i < 3; i++) cyc(1, 120, 0, 0, 0);
    chk("s5_fresh", 32'(match_n), 32'd1);
    cyc(1, 120, 0, 0, 0);
    chk("s5_match", 32'(match_n), 32'd0);

    // Scenario 6: load with a sample in the same cycle, reserved mode.
    do_reset();
    cyc(0, 0, 1, 100, 3);
    for (int i = 0; i < 3; i++) cyc(1, 120, 0, 0, 0);
    cyc(1, 120, 1, 100, 6);
    chk("s6_discard", 32'(match_n), 32'd1);
    for (int i = 0; i < 12; i++) cyc(1, int'($urandom_range(0, 255)), 0, 0, 0);
    chk("s6_nomatch", 32'(match_n), 32'd1);

    // Random compare-core sweep.
    for (int i = 0; i < 40; i++) begin
      int d = int'($urandom_range(0, 255));
      int t = int'($urandom_range(0, 255));
      int m = int'($urandom_range(0, 7));
      if (i % 4 == 0) d = t;
      ub.data = W'(d); ub.threshold = W'(t); ub.mode = 3'(m);
      #1;
      chk("core", 32'(ub.cond), 32'(ref_cond(d, t, m)));
    end

    // Random traffic biased around the threshold.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 19) == 0) begin
        cyc($urandom_range(0, 1) == 1, int'($urandom_range(0, 255)), 1,
            int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
      end else begin
        int d = (m_thr + int'($urandom_range(0, 8)) - 4 + 256) % 256;
        cyc($urandom_range(0, 3) != 0, d, 0, 0, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
